// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                 |
// | Description : Two-port valid/ready arbiter for a single data memory. One   |
// |               request in flight: IDLE -> ACCESS -> RESP, registered reply. |
// |               Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;  |
// |               otherwise port 0 has fixed priority.                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p0_req_valid_i,
  output logic                  p0_req_ready_o,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [31:0]           p0_wdata_i,
  input  logic [2:0]            p0_funct3_i,
  output logic                  p0_rsp_valid_o,
  input  logic                  p0_rsp_ready_i,
  output logic [31:0]           p0_rdata_o,
  output logic                  p0_rsp_err_o,
  input  logic                  p1_req_valid_i,
  output logic                  p1_req_ready_o,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [31:0]           p1_wdata_i,
  input  logic [2:0]            p1_funct3_i,
  output logic                  p1_rsp_valid_o,
  input  logic                  p1_rsp_ready_i,
  output logic [31:0]           p1_rdata_o,
  output logic                  p1_rsp_err_o,
  output logic                  mem_r_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic [2:0]            mem_funct3_o,
  input  logic [31:0]           mem_r_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_gnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_funct3;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_any_valid;
  logic                  w_gnt;
  logic                  w_accept;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [2:0]            w_sel_funct3;
  logic                  w_illegal;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic                  r_last;

  // Contention goes to the port that did not win last time.
  always_comb begin
    w_any_valid = p0_req_valid_i | p1_req_valid_i;
    if (p0_req_valid_i && p1_req_valid_i) begin
      w_gnt = ~r_last;
    end else begin
      w_gnt = p1_req_valid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt;
    end
  end
`else
  always_comb begin
    w_any_valid = p0_req_valid_i | p1_req_valid_i;
    w_gnt       = ~p0_req_valid_i;
  end
`endif

  assign w_sel_we     = w_gnt ? p1_we_i     : p0_we_i;
  assign w_sel_addr   = w_gnt ? p1_addr_i   : p0_addr_i;
  assign w_sel_wdata  = w_gnt ? p1_wdata_i  : p0_wdata_i;
  assign w_sel_funct3 = w_gnt ? p1_funct3_i : p0_funct3_i;
  assign w_accept     = (r_state == ST_IDLE) && w_any_valid;

  always_comb begin
    w_illegal = 1'b1;
    case (w_sel_funct3)
      3'd0, 3'd1, 3'd2: w_illegal = 1'b0;
      3'd4, 3'd5:       w_illegal = w_sel_we;
      default:          w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    p0_req_ready_o = 1'b0;
    p1_req_ready_o = 1'b0;
    p0_rsp_valid_o = 1'b0;
    p1_rsp_valid_o = 1'b0;
    p0_rdata_o     = '0;
    p1_rdata_o     = '0;
    p0_rsp_err_o   = 1'b0;
    p1_rsp_err_o   = 1'b0;
    mem_r_en_o     = 1'b0;
    mem_wr_en_o    = 1'b0;
    mem_addr_o     = '0;
    mem_wr_data_o  = '0;
    mem_funct3_o   = '0;
    case (r_state)
      ST_IDLE: begin
        p0_req_ready_o = w_any_valid & ~w_gnt;
        p1_req_ready_o = w_any_valid & w_gnt;
        if (w_any_valid) begin
          w_next_state = w_illegal ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_r_en_o    = ~r_we;
        mem_wr_en_o   = r_we;
        mem_addr_o    = r_addr;
        mem_wr_data_o = r_wdata;
        mem_funct3_o  = r_funct3;
        w_next_state  = ST_RESP;
      end
      ST_RESP: begin
        if (r_gnt) begin
          p1_rsp_valid_o = 1'b1;
          p1_rdata_o     = r_rdata;
          p1_rsp_err_o   = r_err;
          if (p1_rsp_ready_i) w_next_state = ST_IDLE;
        end else begin
          p0_rsp_valid_o = 1'b1;
          p0_rdata_o     = r_rdata;
          p0_rsp_err_o   = r_err;
          if (p0_rsp_ready_i) w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read data is cleared on accept so stores and illegal requests reply with 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gnt    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_gnt    <= w_gnt;
      r_we     <= w_sel_we;
      r_addr   <= w_sel_addr;
      r_wdata  <= w_sel_wdata;
      r_funct3 <= w_sel_funct3;
      r_rdata  <= '0;
      r_err    <= w_illegal;
    end else if (r_state == ST_ACCESS) begin
      r_rdata  <= r_we ? 32'd0 : mem_r_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Testbench for dmem_arbiter: directed scenarios plus randomized two-port traffic,
// all checked against a transaction-level model with its own shadow memory.
module tb_dmem_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req_valid_i = 1'b0, p1_req_valid_i = 1'b0;
  logic          p0_req_ready_o, p1_req_ready_o;
  logic          p0_we_i = 1'b0, p1_we_i = 1'b0;
  logic [AW-1:0] p0_addr_i = '0, p1_addr_i = '0;
  logic [31:0]   p0_wdata_i = '0, p1_wdata_i = '0;
  logic [2:0]    p0_funct3_i = '0, p1_funct3_i = '0;
  logic          p0_rsp_valid_o, p1_rsp_valid_o;
  logic          p0_rsp_ready_i = 1'b1, p1_rsp_ready_i = 1'b1;
  logic [31:0]   p0_rdata_o, p1_rdata_o;
  logic          p0_rsp_err_o, p1_rsp_err_o;
  logic          mem_r_en_o, mem_wr_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wr_data_o;
  logic [2:0]    mem_funct3_o;
  logic [31:0]   mem_r_data_i;

  logic [31:0]   mem     [0:(1<<AW)-1];
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  int            checks = 0, failures = 0;
  int            wr_cycles = 0, rd_cycles = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_valid_i(p0_req_valid_i), .p0_req_ready_o(p0_req_ready_o), .p0_we_i(p0_we_i),
    .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i), .p0_funct3_i(p0_funct3_i),
    .p0_rsp_valid_o(p0_rsp_valid_o), .p0_rsp_ready_i(p0_rsp_ready_i),
    .p0_rdata_o(p0_rdata_o), .p0_rsp_err_o(p0_rsp_err_o),
    .p1_req_valid_i(p1_req_valid_i), .p1_req_ready_o(p1_req_ready_o), .p1_we_i(p1_we_i),
    .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_funct3_i(p1_funct3_i),
    .p1_rsp_valid_o(p1_rsp_valid_o), .p1_rsp_ready_i(p1_rsp_ready_i),
    .p1_rdata_o(p1_rdata_o), .p1_rsp_err_o(p1_rsp_err_o),
    .mem_r_en_o(mem_r_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_funct3_o(mem_funct3_o), .mem_r_data_i(mem_r_data_i)
  );

  function automatic logic [31:0] load_fn(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd2:    return w;
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_fn(input logic [31:0] old, input logic [31:0] d,
                                           input logic [2:0] f);
    case (f)
      3'd0:    return {old[31:8], d[7:0]};
      3'd1:    return {old[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic legal(input logic we, input logic [2:0] f);
    if (we) return f <= 3'd2;
    return (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
  endfunction

  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return last ? 0 : 1;
`else
      return (last === 1'bx) ? 0 : 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Environment memory: combinational funct3-sized read, write on the clock edge.
  assign mem_r_data_i = load_fn(mem[mem_addr_o], mem_funct3_o);
  always @(posedge clk) begin
    if (mem_wr_en_o) mem[mem_addr_o] <= store_fn(mem[mem_addr_o], mem_wr_data_o, mem_funct3_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic          m_busy, m_last, m_we, m_ok;
  int            m_port, m_age;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [2:0]    m_f3;

  initial begin
    int  choice;
    logic acc, rsp;
    m_busy = 1'b0; m_last = 1'b1; m_port = 0; m_age = 0;
    m_we = 1'b0; m_ok = 1'b1; m_addr = '0; m_wdata = '0; m_rdata = '0; m_f3 = '0;
    forever begin
      @(negedge clk);
      wr_cycles += int'(mem_wr_en_o);
      rd_cycles += int'(mem_r_en_o);
      if (rst) begin
        m_busy = 1'b0;
        m_last = 1'b1;
        chk("rst_ready", {p0_req_ready_o, p1_req_ready_o}, 0);
        chk("rst_rsp_valid", {p0_rsp_valid_o, p1_rsp_valid_o}, 0);
        chk("rst_rsp_err", {p0_rsp_err_o, p1_rsp_err_o}, 0);
        chk("rst_mem_en", {mem_r_en_o, mem_wr_en_o}, 0);
        chk("rst_mem_addr", 32'(mem_addr_o), 0);
        chk("rst_mem_wdata", mem_wr_data_o, 0);
        chk("rst_mem_f3", 32'(mem_funct3_o), 0);
        chk("rst_rdata0", p0_rdata_o, 0);
        chk("rst_rdata1", p1_rdata_o, 0);
      end else begin
        choice = -1; acc = 1'b0; rsp = 1'b0;
        if (!m_busy) choice = pick(p0_req_valid_i, p1_req_valid_i, m_last);
        else begin
          acc = m_ok && (m_age == 0);
          rsp = m_age >= (m_ok ? 1 : 0);
        end
        chk("ready0", p0_req_ready_o, choice == 0);
        chk("ready1", p1_req_ready_o, choice == 1);
        chk("mem_r_en", mem_r_en_o, acc && !m_we);
        chk("mem_wr_en", mem_wr_en_o, acc && m_we);
        if (acc) begin
          chk("mem_addr", 32'(mem_addr_o), 32'(m_addr));
          chk("mem_wdata", mem_wr_data_o, m_wdata);
          chk("mem_f3", 32'(mem_funct3_o), 32'(m_f3));
        end
        chk("rsp_valid0", p0_rsp_valid_o, rsp && m_port == 0);
        chk("rsp_valid1", p1_rsp_valid_o, rsp && m_port == 1);
        if (rsp) begin
          chk("rsp_rdata", (m_port == 0) ? p0_rdata_o : p1_rdata_o, m_rdata);
          chk("rsp_err", (m_port == 0) ? p0_rsp_err_o : p1_rsp_err_o, !m_ok);
        end
        if (!m_busy) begin
          if (choice >= 0) begin
            m_port  = choice;
            m_we    = (choice == 0) ? p0_we_i : p1_we_i;
            m_addr  = (choice == 0) ? p0_addr_i : p1_addr_i;
            m_wdata = (choice == 0) ? p0_wdata_i : p1_wdata_i;
            m_f3    = (choice == 0) ? p0_funct3_i : p1_funct3_i;
            m_ok    = legal(m_we, m_f3);
            m_rdata = '0;
            m_last  = (choice == 1);
            m_age   = 0;
            m_busy  = 1'b1;
          end
        end else begin
          if (acc) begin
            if (m_we) ref_mem[m_addr] = store_fn(ref_mem[m_addr], m_wdata, m_f3);
            else      m_rdata = load_fn(ref_mem[m_addr], m_f3);
          end
          if (rsp && ((m_port == 0) ? p0_rsp_ready_i : p1_rsp_ready_i)) m_busy = 1'b0;
          else m_age++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int port, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [2:0] f);
    if (port == 0) begin
      p0_req_valid_i = v; p0_we_i = we; p0_addr_i = a; p0_wdata_i = d; p0_funct3_i = f;
    end else begin
      p1_req_valid_i = v; p1_we_i = we; p1_addr_i = a; p1_wdata_i = d; p1_funct3_i = f;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // One request on a port; lat counts negedges from handshake cycle to first rsp_valid.
  task automatic do_req(input int port, input logic we, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        output logic [31:0] rd, output logic er, output int lat);
    int   n;
    logic hs, rv;
    rd = '0; er = 1'b0; lat = 0;
    @(posedge clk); #1;
    set_req(port, 1'b1, we, a, d, f);
    if (port == 0) p0_rsp_ready_i = 1'b1; else p1_rsp_ready_i = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = (port == 0) ? p0_req_ready_o : p1_req_ready_o;
      n++;
    end
    if (!hs) timeout("req_handshake");
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, '0, '0, '0);
    lat = 0; rv = 1'b0;
    while (!rv && lat < 50) begin
      @(negedge clk);
      lat++;
      rv = (port == 0) ? p0_rsp_valid_o : p1_rsp_valid_o;
    end
    if (!rv) timeout("rsp_valid");
    rd = (port == 0) ? p0_rdata_o : p1_rdata_o;
    er = (port == 0) ? p0_rsp_err_o : p1_rsp_err_o;
  endtask

  task automatic rand_req(input int port);
    set_req(port, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            3'($urandom_range(0, 7)));
  endtask

  initial begin
    logic [31:0] rd, cap;
    logic        er, hs0, hs1;
    int          lat, w0, r0, ng, cyc;
    int          grants [6];
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // 1: store then load word, latency and single write pulse
    w0 = wr_cycles;
    do_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 3'b010, rd, er, lat);
    chk("t1_sw_lat", lat, 2);
    chk("t1_sw_rdata", rd, 32'd0);
    chk("t1_wr_pulse", wr_cycles - w0, 1);
    do_req(0, 1'b0, 10'd5, 32'd0, 3'b010, rd, er, lat);
    chk("t1_lw_lat", lat, 2);
    chk("t1_lw_rdata", rd, 32'hDEADBEEF);
    chk("t1_lw_err", er, 1'b0);

    // 2: sign/zero extension of byte and half loads
    do_req(0, 1'b1, 10'd3, 32'h000000F0, 3'b010, rd, er, lat);
    do_req(1, 1'b0, 10'd3, 32'd0, 3'b000, rd, er, lat);
    chk("t2_lb", rd, 32'hFFFFFFF0);
    do_req(1, 1'b0, 10'd3, 32'd0, 3'b100, rd, er, lat);
    chk("t2_lbu", rd, 32'h000000F0);
    do_req(1, 1'b1, 10'd3, 32'h00008001, 3'b001, rd, er, lat);
    do_req(1, 1'b0, 10'd3, 32'd0, 3'b001, rd, er, lat);
    chk("t2_lh", rd, 32'hFFFF8001);
    do_req(1, 1'b0, 10'd3, 32'd0, 3'b101, rd, er, lat);
    chk("t2_lhu", rd, 32'h00008001);

    // 4: illegal funct3 never touches memory
    w0 = wr_cycles; r0 = rd_cycles;
    do_req(0, 1'b0, 10'd5, 32'd0, 3'b011, rd, er, lat);
    chk("t4_err", er, 1'b1);
    chk("t4_rdata", rd, 32'd0);
    chk("t4_lat", lat, 1);
    chk("t4_mem_en", (wr_cycles - w0) + (rd_cycles - r0), 0);

    // 5: response back-pressure blocks port 1
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 10'd5, 32'd0, 3'b010);
    p0_rsp_ready_i = 1'b0;
    p1_rsp_ready_i = 1'b1;
    ng = 0;
    while (ng < 50 && !p0_req_ready_o) begin @(negedge clk); ng++; end
    if (!p0_req_ready_o) timeout("t5_accept");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'd3, 32'd0, 3'b010);
    ng = 0;
    while (ng < 50 && !p0_rsp_valid_o) begin @(negedge clk); ng++; end
    if (!p0_rsp_valid_o) timeout("t5_rsp");
    cap = p0_rdata_o;
    chk("t5_rdata", cap, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", p0_rsp_valid_o, 1'b1);
      chk("t5_hold_rdata", p0_rdata_o, cap);
      chk("t5_p1_blocked", p1_req_ready_o, 1'b0);
    end
    @(posedge clk); #1 p0_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_p1_still_blocked", p1_req_ready_o, 1'b0);
    @(negedge clk);
    chk("t5_p1_accept_next", p1_req_ready_o, 1'b1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    ng = 0;
    while (ng < 50 && !p1_rsp_valid_o) begin @(negedge clk); ng++; end
    if (!p1_rsp_valid_o) timeout("t5_p1_rsp");
    chk("t5_p1_rdata", p1_rdata_o, 32'h00008001);

    // 6: reset during the ACCESS cycle of a store
    do_req(0, 1'b1, 10'd9, 32'h12345678, 3'b010, rd, er, lat);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 10'd9, 32'hCAFEF00D, 3'b010);
    ng = 0;
    while (ng < 50 && !p0_req_ready_o) begin @(negedge clk); ng++; end
    if (!p0_req_ready_o) timeout("t6_accept");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    chk("t6_in_access", mem_wr_en_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_wr_en", mem_wr_en_o, 1'b0);
    chk("t6_rst_addr", 32'(mem_addr_o), 0);
    chk("t6_rst_wdata", mem_wr_data_o, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    do_req(0, 1'b0, 10'd9, 32'd0, 3'b010, rd, er, lat);
    chk("t6_unchanged", rd, 32'h12345678);

    // 3: continuous contention from both ports after reset
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 10'd1, 32'd0, 3'b010);
    set_req(1, 1'b1, 1'b0, 10'd2, 32'd0, 3'b010);
    ng = 0; cyc = 0;
    while (ng < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (p0_req_ready_o) begin grants[ng] = 0; ng++; end
      else if (p1_req_ready_o) begin grants[ng] = 1; ng++; end
    end
    if (ng < 6) timeout("t3_grants");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      chk("t3_grant", grants[i], i % 2);
`else
      chk("t3_grant", grants[i], 0);
`endif
    end

    // Randomized two-port traffic; a waiting request is held until its handshake.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs0 = p0_req_valid_i & p0_req_ready_o;
      hs1 = p1_req_valid_i & p1_req_ready_o;
      @(posedge clk); #1;
      if (hs0 || !p0_req_valid_i) begin
        if ($urandom_range(0, 3) != 0) rand_req(0);
        else set_req(0, 1'b0, 1'b0, '0, '0, '0);
      end
      if (hs1 || !p1_req_valid_i) begin
        if ($urandom_range(0, 3) != 0) rand_req(1);
        else set_req(1, 1'b0, 1'b0, '0, '0, '0);
      end
      p0_rsp_ready_i = ($urandom_range(0, 3) != 0);
      p1_rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    p0_rsp_ready_i = 1'b1;
    p1_rsp_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++) chk("final_mem", mem[a], ref_mem[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
